// File: rtl/player_move_unit_pkg.sv
// Shared types and constants for the local-player movement controller:
// facing enum, game-state codes, wall bounds and per-ID spawn tables.
package player_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_e;

  localparam logic [2:0] START = 3'd0;
  localparam logic [2:0] PLAY  = 3'd2;

  localparam logic [8:0] X_MIN = 9'd32;
  localparam logic [8:0] X_MAX = 9'd448;
  localparam logic [8:0] Y_MIN = 9'd48;
  localparam logic [8:0] Y_MAX = 9'd304;

  // Element [id] of each table is the spawn coordinate for that player ID.
  localparam logic [3:0][8:0] SPAWN_X = {9'd352, 9'd96, 9'd352, 9'd96};
  localparam logic [3:0][8:0] SPAWN_Y = {9'd240, 9'd240, 9'd96, 9'd96};

  // Saturate a widened signed coordinate into [lo,hi]; never wraps.
  function automatic logic [8:0] clamp9(input logic signed [9:0] v,
                                        input logic [8:0] lo,
                                        input logic [8:0] hi);
    if (v < $signed({1'b0, lo}))      return lo;
    else if (v > $signed({1'b0, hi})) return hi;
    else                              return v[8:0];
  endfunction

endpackage

// File: rtl/player_move_unit_if.sv
// Frame-rate control/status bundle between the game core and the movement unit.
interface player_move_unit_if;
  logic [1:0] num_players;
  logic       left, right, up, down;
  logic       chop, carry;
  logic [2:0] game_state;
  logic [1:0] local_player_ID;
  logic [8:0] player_a_x, player_b_x, player_c_x;
  logic [8:0] player_a_y, player_b_y, player_c_y;
  logic [8:0] player_loc_x, player_loc_y;
  logic [1:0] player_direction;

  modport master (
    output num_players, left, right, up, down, chop, carry, game_state,
           local_player_ID, player_a_x, player_b_x, player_c_x,
           player_a_y, player_b_y, player_c_y,
    input  player_loc_x, player_loc_y, player_direction
  );

  modport slave (
    input  num_players, left, right, up, down, chop, carry, game_state,
           local_player_ID, player_a_x, player_b_x, player_c_x,
           player_a_y, player_b_y, player_c_y,
    output player_loc_x, player_loc_y, player_direction
  );
endinterface

// File: rtl/player_move_unit_collide.sv
// Combinational bounding-box overlap test of a candidate position against
// the other players that are actually in the game.
module player_collide_check import player_pkg::*; #(
  parameter int SPRITE = 32
) (
  input  logic [8:0]      cand_x,
  input  logic [8:0]      cand_y,
  input  logic [2:0][8:0] oth_x,
  input  logic [2:0][8:0] oth_y,
  input  logic [1:0]      num_players,
  input  logic [1:0]      local_player_ID,
  output logic            blocked
);
  logic [2:0] total;
  logic [2:0] hit;

  assign total = (num_players == 2'd0) ? 3'd4 : {1'b0, num_players};

  for (genvar s = 0; s < 3; s++) begin : g_slot
    logic [2:0]        slot_id;
    logic              present;
    logic signed [9:0] dx, dy, adx, ady;

    // Slots list the other IDs in ascending order with the local ID skipped.
    assign slot_id = (3'(s) < {1'b0, local_player_ID}) ? 3'(s) : 3'(s + 1);
    assign present = slot_id < total;
    assign dx      = $signed({1'b0, cand_x}) - $signed({1'b0, oth_x[s]});
    assign dy      = $signed({1'b0, cand_y}) - $signed({1'b0, oth_y[s]});
    assign adx     = dx[9] ? -dx : dx;
    assign ady     = dy[9] ? -dy : dy;
    assign hit[s]  = present && (adx < 10'(SPRITE)) && (ady < 10'(SPRITE));
  end

  assign blocked = |hit;
endmodule

// File: rtl/player_move_unit.sv
// Per-frame local player position/facing register, stepped on vsync.
// Player-vs-player rejection is built only when PLAYER_COLLIDE_EN is defined.
module player_move_unit import player_pkg::*; #(
  parameter int STEP   = 2,
  parameter int SPRITE = 32
) (
  input  logic vsync,
  input  logic reset,
  player_move_unit_if.slave pif
);
  dir_e              sel;
  logic              any_dir;
  logic signed [9:0] cx_w, cy_w;
  logic [8:0]        cand_x, cand_y;
  logic              blocked;
  logic [8:0]        loc_x, loc_y;
  dir_e              dir_q;

  always_comb begin
    any_dir = 1'b1;
    sel     = DOWN;
    if      (pif.up)    sel = UP;
    else if (pif.down)  sel = DOWN;
    else if (pif.left)  sel = LEFT;
    else if (pif.right) sel = RIGHT;
    else                any_dir = 1'b0;
  end

  // Candidate is built one bit wider so a step past either wall saturates.
  always_comb begin
    cx_w = $signed({1'b0, loc_x});
    cy_w = $signed({1'b0, loc_y});
    case (sel)
      UP:      cy_w = cy_w - 10'(STEP);
      DOWN:    cy_w = cy_w + 10'(STEP);
      LEFT:    cx_w = cx_w - 10'(STEP);
      default: cx_w = cx_w + 10'(STEP);
    endcase
    cand_x = clamp9(cx_w, X_MIN, X_MAX);
    cand_y = clamp9(cy_w, Y_MIN, Y_MAX);
  end

`ifdef PLAYER_COLLIDE_EN
  player_collide_check #(.SPRITE(SPRITE)) u_collide (
    .cand_x          (cand_x),
    .cand_y          (cand_y),
    .oth_x           ({pif.player_c_x, pif.player_b_x, pif.player_a_x}),
    .oth_y           ({pif.player_c_y, pif.player_b_y, pif.player_a_y}),
    .num_players     (pif.num_players),
    .local_player_ID (pif.local_player_ID),
    .blocked         (blocked)
  );
  logic unused_ok;
  assign unused_ok = pif.carry;
`else
  localparam int UNUSED_SPRITE = SPRITE;
  logic unused_ok;
  assign blocked   = 1'b0;
  assign unused_ok = ^{pif.carry, pif.num_players,
                       pif.player_a_x, pif.player_b_x, pif.player_c_x,
                       pif.player_a_y, pif.player_b_y, pif.player_c_y};
`endif

  always_ff @(posedge vsync or negedge reset) begin
    if (!reset) begin
      loc_x <= SPAWN_X[pif.local_player_ID];
      loc_y <= SPAWN_Y[pif.local_player_ID];
      dir_q <= DOWN;
    end else if (pif.game_state == START) begin
      loc_x <= SPAWN_X[pif.local_player_ID];
      loc_y <= SPAWN_Y[pif.local_player_ID];
      dir_q <= DOWN;
    end else if (pif.game_state == PLAY && any_dir) begin
      // Facing follows the button even when the step itself is refused.
      dir_q <= sel;
      if (!pif.chop && !blocked) begin
        loc_x <= cand_x;
        loc_y <= cand_y;
      end
    end
  end

  assign pif.player_loc_x     = loc_x;
  assign pif.player_loc_y     = loc_y;
  assign pif.player_direction = dir_q;
endmodule

// File: tb/tb_player_move_unit.sv
// Directed bench for player_move_unit with an arithmetic reference model
// compared every frame, plus literal expectations at key points.
module tb_player_move_unit;
  logic vsync = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  player_move_unit_if pif();

  player_move_unit dut (
    .vsync (vsync),
    .reset (rst_n),
    .pif   (pif)
  );

  always #5 vsync = ~vsync;

  int mx, my, md;

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int spawn_x(int id);
    return (id % 2 == 1) ? 352 : 96;
  endfunction

  function automatic int spawn_y(int id);
    return (id >= 2) ? 240 : 96;
  endfunction

  function automatic bit model_hit(int cx, int cy);
`ifdef PLAYER_COLLIDE_EN
    int ox[3];
    int oy[3];
    int total;
    int lid;
    int slot;
    ox[0] = pif.player_a_x; ox[1] = pif.player_b_x; ox[2] = pif.player_c_x;
    oy[0] = pif.player_a_y; oy[1] = pif.player_b_y; oy[2] = pif.player_c_y;
    total = (pif.num_players == 0) ? 4 : int'(pif.num_players);
    lid   = pif.local_player_ID;
    for (int id = 0; id < total; id++) begin
      if (id != lid) begin
        slot = (id < lid) ? id : id - 1;
        if (iabs(cx - ox[slot]) < 32 && iabs(cy - oy[slot]) < 32) return 1'b1;
      end
    end
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge vsync or negedge rst_n) begin : model
    int nx, ny, nd;
    bit act;
    if (!rst_n) begin
      mx <= spawn_x(pif.local_player_ID);
      my <= spawn_y(pif.local_player_ID);
      md <= 2;
    end else if (pif.game_state == 3'd0) begin
      mx <= spawn_x(pif.local_player_ID);
      my <= spawn_y(pif.local_player_ID);
      md <= 2;
    end else if (pif.game_state == 3'd2) begin
      nx = mx; ny = my; nd = md; act = 1'b1;
      if      (pif.up)    begin nd = 0; ny = my - 2; end
      else if (pif.down)  begin nd = 2; ny = my + 2; end
      else if (pif.left)  begin nd = 3; nx = mx - 2; end
      else if (pif.right) begin nd = 1; nx = mx + 2; end
      else act = 1'b0;
      nx = (nx < 32) ? 32 : (nx > 448) ? 448 : nx;
      ny = (ny < 48) ? 48 : (ny > 304) ? 304 : ny;
      if (act) begin
        md <= nd;
        if (!pif.chop && !model_hit(nx, ny)) begin
          mx <= nx;
          my <= ny;
        end
      end
    end
  end

  always @(negedge vsync) begin
    if (chk_en) begin
      checks++;
      if (int'(pif.player_loc_x) != mx || int'(pif.player_loc_y) != my ||
          int'(pif.player_direction) != md) begin
        errors++;
        $display("FAIL model t=%0t got x=%0d y=%0d d=%0d want x=%0d y=%0d d=%0d",
                 $time, pif.player_loc_x, pif.player_loc_y, pif.player_direction,
                 mx, my, md);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_pos(input string nm, input int x, input int y, input int d);
    chk({nm, ".x"}, int'(pif.player_loc_x), x);
    chk({nm, ".y"}, int'(pif.player_loc_y), y);
    chk({nm, ".dir"}, int'(pif.player_direction), d);
  endtask

  task automatic frames(input int n);
    repeat (n) @(negedge vsync);
  endtask

  initial begin
    pif.num_players = 2'd1;
    {pif.left, pif.right, pif.up, pif.down, pif.chop, pif.carry} = '0;
    pif.game_state = 3'd2;
    pif.local_player_ID = 2'd0;
    pif.player_a_x = 9'd0; pif.player_b_x = 9'd0; pif.player_c_x = 9'd0;
    pif.player_a_y = 9'd0; pif.player_b_y = 9'd0; pif.player_c_y = 9'd0;

    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    chk_pos("reset_id0", 96, 96, 2);
    @(negedge vsync); rst_n = 1'b1;
    frames(3);
    chk_pos("idle_hold", 96, 96, 2);

    pif.right = 1'b1; pif.carry = 1'b1;
    frames(50);
    chk_pos("right50", 196, 96, 1);
    pif.right = 1'b0; pif.carry = 1'b0; pif.left = 1'b1;
    frames(10);
    chk_pos("left10", 176, 96, 3);

    pif.left = 1'b0; pif.right = 1'b1;
    frames(300);
    chk_pos("right_sat", 448, 96, 1);
    pif.right = 1'b0; pif.up = 1'b1;
    frames(30);
    chk_pos("up_sat", 448, 48, 0);
    pif.up = 1'b0;

    #2 rst_n = 1'b0;
    #1 chk_pos("mid_reset", 96, 96, 2);
    @(negedge vsync); rst_n = 1'b1;

    pif.num_players = 2'd2; pif.player_a_x = 9'd140; pif.player_a_y = 9'd96;
    pif.right = 1'b1;
    frames(10);
`ifdef PLAYER_COLLIDE_EN
    chk_pos("collide_stop", 108, 96, 1);
    pif.num_players = 2'd1;
    frames(5);
    chk_pos("collide_absent", 118, 96, 1);
`else
    chk_pos("no_collide", 116, 96, 1);
    pif.num_players = 2'd1;
    frames(5);
    chk_pos("no_collide2", 126, 96, 1);
`endif
    pif.right = 1'b0;

    pif.game_state = 3'd0;
    frames(1);
    chk_pos("start_spawn", 96, 96, 2);
    pif.game_state = 3'd2;

    pif.up = 1'b1; pif.right = 1'b1;
    frames(5);
    chk_pos("up_over_right", 96, 86, 0);
    pif.up = 1'b0; pif.chop = 1'b1;
    frames(5);
    chk_pos("chop_freeze", 96, 86, 1);
    pif.chop = 1'b0; pif.right = 1'b0;

    pif.up = 1'b1; pif.down = 1'b1; pif.left = 1'b1;
    frames(3);
    chk_pos("up_over_down", 96, 80, 0);
    pif.up = 1'b0;
    frames(2);
    chk_pos("down_over_left", 96, 84, 2);
    pif.down = 1'b0; pif.left = 1'b0;

    pif.game_state = 3'd3; pif.left = 1'b1;
    frames(5);
    chk_pos("paused_freeze", 96, 84, 2);
    pif.left = 1'b0;
    pif.game_state = 3'd0;
    frames(1);
    chk_pos("start_again", 96, 96, 2);

    pif.local_player_ID = 2'd2;
    #1 rst_n = 1'b0;
    #1 chk_pos("reset_id2", 96, 240, 2);
    @(negedge vsync); rst_n = 1'b1; pif.game_state = 3'd2;
    pif.down = 1'b1;
    frames(40);
    chk_pos("down_sat", 96, 304, 2);
    pif.down = 1'b0;
    frames(2);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
